// File: rtl/lsq_mem_unit.sv
// lsq_mem_unit
// Memory-access stage behind the load/store queue. Takes the LSQ head,
// issues one data-memory transaction at a time over req/gnt + rvalid and
// offers load results to the CDB arbiter until granted. Stores issue only
// when the ROB head commits them; loads issue speculatively and are
// discarded on flush.
//
// Optional feature macro: LSQ_MEM_ALIGN_CHECK_EN
//   defined   - misaligned accesses (addr[1:0] != 0) bypass memory; a load
//               goes straight to the CDB with result 0 and cdb_exc=1, a store
//               is dropped and store_done pulses with cdb_exc=1.
//   undefined - no check, cdb_exc tied 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   head_*              LSQ head entry (valid/ready/load/addr/data/tag)
//   rob_head_tag/valid  ROB head, gates store issue
//   flush               mispredict flush
//   lsq_rd_en           combinational dequeue pulse in the accept cycle
//   dmem_*              data-memory request/response interface
//   cdb_*               load-result broadcast, held until cdb_grant
//   store_done          one-cycle pulse after a store is accepted by memory
//   busy                unit is not idle
module lsq_mem_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             head_valid,
    input  logic             head_ready,
    input  logic             head_load,
    input  logic [XLEN-1:0]  head_addr,
    input  logic [XLEN-1:0]  head_data,
    input  logic [TAG_W-1:0] head_tag,
    input  logic [TAG_W-1:0] rob_head_tag,
    input  logic             rob_head_valid,
    input  logic             flush,
    output logic             lsq_rd_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_result,
    input  logic             cdb_grant,
    output logic             cdb_exc,
    output logic             store_done,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, CDB, DRAIN} state_t;

    state_t state, state_next;

    logic             load_q;
    logic             flushed_q;     // flush seen while a load request was pending
    logic             exc_q;
    logic             store_done_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;
    logic             commit_ok;
    logic             accept;
    logic             misalign;

    // rob_head_valid gating keeps a tag-0 head from matching an empty ROB.
    assign commit_ok = rob_head_valid && (rob_head_tag == head_tag);
    assign accept    = (state == IDLE) && !reset && head_valid && head_ready &&
                       !flush && (head_load || commit_ok);

`ifdef LSQ_MEM_ALIGN_CHECK_EN
    assign misalign = (head_addr[1:0] != 2'b00);
    assign cdb_exc  = exc_q && ((state == CDB) || store_done_q);
`else
    assign misalign = 1'b0;
    assign cdb_exc  = 1'b0;
`endif

    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign cdb_tag    = tag_q;
    assign cdb_result = result_q;
    assign store_done = store_done_q;

    always_comb begin
        state_next = state;
        lsq_rd_en  = accept;
        dmem_req   = (state == REQ);
        dmem_we    = (state == REQ) && !load_q;
        cdb_valid  = (state == CDB);
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misalign)
                        state_next = head_load ? CDB : IDLE;
                    else
                        state_next = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (!load_q)
                        state_next = IDLE;
                    else if (flush || flushed_q)
                        state_next = DRAIN;
                    else
                        state_next = WAIT;
                end
            end
            WAIT: begin
                // A response arriving together with flush is already consumed,
                // so there is nothing left to drain.
                if (dmem_rvalid)
                    state_next = flush ? IDLE : CDB;
                else if (flush)
                    state_next = DRAIN;
            end
            CDB: begin
                if (cdb_grant || flush)
                    state_next = IDLE;
            end
            DRAIN: begin
                if (dmem_rvalid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            load_q       <= 1'b0;
            flushed_q    <= 1'b0;
            exc_q        <= 1'b0;
            store_done_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            result_q     <= '0;
            tag_q        <= '0;
        end else begin
            state        <= state_next;
            store_done_q <= 1'b0;
            if (accept) begin
                load_q    <= head_load;
                addr_q    <= head_addr;
                wdata_q   <= head_data;
                tag_q     <= head_tag;
                flushed_q <= 1'b0;
                exc_q     <= misalign;
                result_q  <= '0;
                if (misalign && !head_load)
                    store_done_q <= 1'b1;
            end
            if (state == REQ && flush)
                flushed_q <= 1'b1;
            if (state == REQ && dmem_gnt && !load_q)
                store_done_q <= 1'b1;
            if (state == WAIT && dmem_rvalid)
                result_q <= dmem_rdata;
        end
    end

endmodule
